// File: rtl/usb_loader_pkg.sv
// Shared constants, write-FSM state and bus decode helper for the USB memory loader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package usb_loader_pkg;

    localparam logic [7:0] REG_ADDR = 8'h02;
    localparam logic [7:0] REG_DATA = 8'h03;
    localparam logic [7:0] REG_CTRL = 8'h04;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_CLR = 1;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic wr_addr;
        logic wr_data;
        logic wr_ctrl;
    } bus_dec_t;

    function automatic bus_dec_t bus_decode(input logic wr, input logic [7:0] addr);
        bus_dec_t d;
        d.wr_addr = wr && (addr == REG_ADDR);
        d.wr_data = wr && (addr == REG_DATA);
        d.wr_ctrl = wr && (addr == REG_CTRL);
        return d;
    endfunction

endpackage

// File: rtl/usb_word_assembler.sv
// Packs DATA bytes little-endian into a 32-bit word and pulses word_done when full.
// Latency: word_done/word_dat valid the cycle after the 4th byte's edge.
// Backpressure: none; clr discards any partial word.
module usb_word_assembler
    import usb_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    input  logic              clr,
    output logic [WORD_W-1:0] word_dat,
    output logic              word_done
);

    logic [BCNT_W-1:0] byte_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            word_dat  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clr) begin
                byte_cnt <= '0;
            end else if (byte_vld) begin
                // Shift right so the first byte ends up in [7:0] after four bytes.
                word_dat <= {byte_dat, word_dat[WORD_W-1:8]};
                if (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1)) begin
                    byte_cnt  <= '0;
                    word_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + BCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/usb_mem_loader.sv
// EPP register target: loads words into CPU memory with auto-increment and owns cpu_run.
// Latency: 4th DATA strobe at edge N -> mem_we high after edge N+1; optional checksum via USB_LOADER_CHECKSUM_EN.
// Backpressure: mem_we held until mem_ack; a word completing while still pending is dropped (sticky overflow).
module usb_mem_loader
    import usb_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_addr,
    input  logic              bus_write,
    input  logic              bus_read,
    input  logic [7:0]        bus_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              cpu_run,
    output logic              overflow,
    output logic [15:0]       word_count,
    output logic [7:0]        checksum
);

    bus_dec_t          dec;
    logic              ctrl_clr;
    logic              asm_clr;
    logic [WORD_W-1:0] word_dat;
    logic              word_done;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W+7:0] addr_cat;
    wr_state_t         state, state_nxt;
    logic              accept;
    logic              load_word;
    logic              drop_word;
    logic              unused_bus_read;

    // Reads are handled entirely by the driver side.
    assign unused_bus_read = bus_read;

    assign dec      = bus_decode(bus_write, bus_addr);
    assign ctrl_clr = dec.wr_ctrl && bus_data[CTRL_CLR];
    assign asm_clr  = dec.wr_addr || ctrl_clr;
    assign addr_cat = {load_addr, bus_data};

    usb_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_vld  (dec.wr_data),
        .byte_dat  (bus_data),
        .clr       (asm_clr),
        .word_dat  (word_dat),
        .word_done (word_done)
    );

    // An ADDR write in the same cycle as a completing word wins; the word
    // still goes out to the address that was current before the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_addr <= '0;
        end else if (dec.wr_addr) begin
            load_addr <= addr_cat[ADDR_W-1:0];
        end else if (word_done) begin
            load_addr <= load_addr + ADDR_W'(1);
        end
    end

    assign accept    = (state == PEND) && mem_ack;
    assign load_word = word_done && ((state == IDLE) || mem_ack);
    assign drop_word = word_done && (state == PEND) && !mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (word_done) state_nxt = PEND;
            PEND:    if (mem_ack && !word_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we = (state == PEND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load_word) begin
            mem_addr  <= load_addr;
            mem_wdata <= word_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_run    <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (dec.wr_ctrl) begin
                cpu_run <= bus_data[CTRL_RUN];
            end
            if (ctrl_clr) begin
                overflow   <= 1'b0;
                word_count <= '0;
            end else begin
                if (drop_word) overflow <= 1'b1;
                if (accept) word_count <= word_count + 16'd1;
            end
        end
    end

`ifdef USB_LOADER_CHECKSUM_EN
    // Counts every DATA byte, including bytes of words later discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (ctrl_clr) begin
            checksum <= '0;
        end else if (dec.wr_data) begin
            checksum <= checksum + bus_data;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_usb_mem_loader.sv
// Directed vector bench for usb_mem_loader: table of per-cycle bus/ack stimulus with expected outputs.
module tb_usb_mem_loader;
    import usb_loader_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bus_addr;
    logic        bus_write;
    logic        bus_read;
    logic [7:0]  bus_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        cpu_run;
    logic        overflow;
    logic [15:0] word_count;
    logic [7:0]  checksum;

    int n_cmp = 0;
    int n_bad = 0;

    usb_mem_loader #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_write  (bus_write),
        .bus_read   (bus_read),
        .bus_data   (bus_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .cpu_run    (cpu_run),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  dat;
        logic        ack;
        logic        we;
        logic [15:0] maddr;
        logic [31:0] wdata;
        logic [15:0] cnt;
        logic        ovf;
        logic        run;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d,
                       input logic ack, input logic we, input logic [15:0] ma, input logic [31:0] wd,
                       input logic [15:0] cnt, input logic ovf, input logic run);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.dat = d; v.ack = ack;
        v.we = we; v.maddr = ma; v.wdata = wd; v.cnt = cnt; v.ovf = ovf; v.run = run;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [7:0] a,
                         input logic [7:0] d, input logic ack);
        @(negedge clk);
        bus_write = wr;
        bus_read  = rd;
        bus_addr  = a;
        bus_data  = d;
        mem_ack   = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] pack_out(input logic we, input logic [15:0] ma, input logic [31:0] wd,
                                             input logic [15:0] cnt, input logic ovf, input logic run,
                                             input logic [7:0] cks);
        return {5'd0, we, ma, wd, cnt, ovf, run, cks};
    endfunction

    function automatic logic [7:0] exp_cks(input logic [7:0] model);
`ifdef USB_LOADER_CHECKSUM_EN
        return model;
`else
        return 8'h00 & model;
`endif
    endfunction

    logic [7:0] cks_model;

    initial begin
        rst_n = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_addr = 8'h00; bus_data = 8'h00; mem_ack = 1'b0;
        cks_model = 8'h00;

        //   wr rd addr   dat    ack we  maddr     wdata         cnt  ovf run
        add(1, 0, 8'h02, 8'h00, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(1, 0, 8'h02, 8'h10, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(1, 0, 8'h03, 8'h11, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(1, 0, 8'h03, 8'h22, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(1, 0, 8'h03, 8'h33, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(1, 0, 8'h03, 8'h44, 1, 0, 16'h0000, 32'h00000000, 16'd0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 16'h0010, 32'h44332211, 16'd0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        // Address wrap: load 0xFFFF, two words back to back
        add(1, 0, 8'h02, 8'hFF, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h02, 8'hFF, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h01, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h02, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h03, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h04, 1, 0, 16'h0010, 32'h44332211, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h05, 1, 1, 16'hFFFF, 32'h04030201, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'h06, 1, 0, 16'hFFFF, 32'h04030201, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h07, 1, 0, 16'hFFFF, 32'h04030201, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h08, 1, 0, 16'hFFFF, 32'h04030201, 16'd2, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 16'h0000, 32'h08070605, 16'd2, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 16'h0000, 32'h08070605, 16'd3, 0, 0);
        // Memory stalls: second word dropped, overflow sticks
        add(1, 0, 8'h03, 8'hA1, 0, 0, 16'h0000, 32'h08070605, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hA2, 0, 0, 16'h0000, 32'h08070605, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hA3, 0, 0, 16'h0000, 32'h08070605, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hA4, 0, 0, 16'h0000, 32'h08070605, 16'd3, 0, 0);
        add(0, 0, 8'h00, 8'h00, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(0, 0, 8'h00, 8'h00, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(0, 1, 8'h03, 8'h99, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hB1, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hB2, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hB3, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(1, 0, 8'h03, 8'hB4, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 0, 0);
        add(0, 0, 8'h00, 8'h00, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd3, 1, 0);
        add(1, 0, 8'h04, 8'h02, 0, 1, 16'h0001, 32'hA4A3A2A1, 16'd0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        // Partial word discarded by an ADDR write
        add(1, 0, 8'h03, 8'hAA, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'hBB, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h02, 8'h00, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h02, 8'h20, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'hC1, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'hC2, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'hC3, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(1, 0, 8'h03, 8'hC4, 1, 0, 16'h0001, 32'hA4A3A2A1, 16'd1, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 16'h0020, 32'hC4C3C2C1, 16'd1, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        // Accept and new word completing in the same cycle keeps PEND
        add(1, 0, 8'h02, 8'h00, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(1, 0, 8'h02, 8'h40, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h10, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h20, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h30, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h40, 0, 0, 16'h0020, 32'hC4C3C2C1, 16'd2, 0, 0);
        add(0, 0, 8'h00, 8'h00, 0, 1, 16'h0040, 32'h40302010, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h50, 0, 1, 16'h0040, 32'h40302010, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h60, 0, 1, 16'h0040, 32'h40302010, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h70, 0, 1, 16'h0040, 32'h40302010, 16'd2, 0, 0);
        add(1, 0, 8'h03, 8'h80, 0, 1, 16'h0040, 32'h40302010, 16'd2, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 16'h0041, 32'h80706050, 16'd3, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 16'h0041, 32'h80706050, 16'd4, 0, 0);
        // Run control, ignored reads and unmapped addresses
        add(1, 0, 8'h04, 8'h01, 0, 0, 16'h0041, 32'h80706050, 16'd4, 0, 1);
        add(1, 0, 8'h07, 8'hFF, 0, 0, 16'h0041, 32'h80706050, 16'd4, 0, 1);
        add(0, 1, 8'h04, 8'h00, 0, 0, 16'h0041, 32'h80706050, 16'd4, 0, 1);
        add(0, 1, 8'h03, 8'h55, 1, 0, 16'h0041, 32'h80706050, 16'd4, 0, 1);
        add(1, 0, 8'h05, 8'h03, 1, 0, 16'h0041, 32'h80706050, 16'd4, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack_out(mem_we, mem_addr, mem_wdata, word_count, overflow, cpu_run, checksum),
              pack_out(1'b0, 16'h0000, 32'h0, 16'd0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].dat, vecs[i].ack);
            if (vecs[i].wr && vecs[i].addr == REG_DATA) cks_model = cks_model + vecs[i].dat;
            if (vecs[i].wr && vecs[i].addr == REG_CTRL && vecs[i].dat[CTRL_CLR]) cks_model = 8'h00;
            check($sformatf("vec%0d", i),
                  pack_out(mem_we, mem_addr, mem_wdata, word_count, overflow, cpu_run, checksum),
                  pack_out(vecs[i].we, vecs[i].maddr, vecs[i].wdata, vecs[i].cnt, vecs[i].ovf,
                           vecs[i].run, exp_cks(cks_model)));
        end

        // Reset mid-transfer: pending word and partial word are both lost
        drive(1, 0, 8'h03, 8'h01, 0);
        drive(1, 0, 8'h03, 8'h02, 0);
        drive(1, 0, 8'h03, 8'h03, 0);
        drive(1, 0, 8'h03, 8'h04, 0);
        drive(0, 0, 8'h00, 8'h00, 0);
        check("pend_before_reset", {63'd0, mem_we, mem_addr}, {63'd0, 1'b1, 16'h0042});
        drive(1, 0, 8'h03, 8'h05, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus_write = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", pack_out(mem_we, mem_addr, mem_wdata, word_count, overflow, cpu_run, checksum),
              pack_out(1'b0, 16'h0000, 32'h0, 16'd0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        // Checksum wraps mod 256; also proves the pre-reset partial byte is gone
        drive(1, 0, 8'h03, 8'hFF, 1);
        drive(1, 0, 8'h03, 8'h02, 1);
        check("checksum_wrap", {72'd0, checksum}, {72'd0, exp_cks(8'h01)});
        drive(1, 0, 8'h03, 8'h03, 1);
        drive(1, 0, 8'h03, 8'h04, 1);
        drive(0, 0, 8'h00, 8'h00, 1);
        check("post_reset_word", pack_out(mem_we, mem_addr, mem_wdata, word_count, overflow, cpu_run, checksum),
              pack_out(1'b1, 16'h0000, 32'h040302FF, 16'd0, 1'b0, 1'b0, exp_cks(8'h08)));
        drive(1, 0, 8'h04, 8'h02, 1);
        check("ctrl_clr_keeps_pend", pack_out(mem_we, mem_addr, mem_wdata, word_count, overflow, cpu_run, checksum),
              pack_out(1'b0, 16'h0000, 32'h040302FF, 16'd0, 1'b0, 1'b0, 8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
